// File: rtl/up_loader.sv
// Serial program loader: parses A5/LEN/DATA/CSUM frames from the UART, writes the payload
// into memory from address 0, echoes each frame byte and answers with ACK or NAK.
module up_loader #(
  parameter int unsigned TIMEOUT = 10_000_000,
  parameter int unsigned CNT_W   = 24,
  parameter logic [7:0]  ACK     = 8'h4B,
  parameter logic [7:0]  NAK     = 8'h45
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog,
  input  logic       recieved,
  input  logic [7:0] data_rx,
  input  logic       busy_tx,
  output logic       transmit,
  output logic [7:0] data_tx,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       done,
  output logic       error
);

  localparam logic [7:0]       SYNC = 8'hA5;
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       mem_addr_q, mem_addr_d;
  logic             buf_full_q, buf_full_d;
  logic [7:0]       buf_data_q, buf_data_d;
  logic [1:0]       gap_q, gap_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             error_q, error_d;
  logic             mem_we_q, mem_we_d;
  logic [7:0]       mem_data_q, mem_data_d;
  logic             transmit_q, transmit_d;
  logic [7:0]       data_tx_q, data_tx_d;
  logic             done_q, done_d;
  logic             resp_pend_q, resp_pend_d;
  logic             resp_ack_q, resp_ack_d;
  logic             resp_in_buf_q, resp_in_buf_d;

  logic send_s;
  logic accept_s;
  logic framed_s;

  // Next-state, datapath and output computation
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sum_d         = sum_q;
    mem_addr_d    = mem_addr_q;
    buf_full_d    = buf_full_q;
    buf_data_d    = buf_data_q;
    gap_d         = gap_q;
    tmr_d         = tmr_q;
    error_d       = error_q;
    mem_we_d      = 1'b0;
    mem_data_d    = mem_data_q;
    transmit_d    = 1'b0;
    data_tx_d     = data_tx_q;
    done_d        = 1'b0;
    resp_pend_d   = resp_pend_q;
    resp_ack_d    = resp_ack_q;
    resp_in_buf_d = resp_in_buf_q;

    // gap_q holds off the next pulse until the UART has had time to raise busy_tx
    send_s   = buf_full_q && !busy_tx && (gap_q == 2'd0);
    accept_s = !buf_full_q || send_s;
    framed_s = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);

    if (!prog) begin
      state_d       = S_IDLE;
      buf_full_d    = 1'b0;
      resp_pend_d   = 1'b0;
      resp_in_buf_d = 1'b0;
      gap_d         = 2'd0;
      tmr_d         = {CNT_W{1'b0}};
    end else begin
      gap_d      = (gap_q != 2'd0) ? (gap_q - 2'd1) : 2'd0;
      mem_addr_d = mem_addr_q + {7'd0, mem_we_q};

      if (recieved) begin
        tmr_d = {CNT_W{1'b0}};
      end else if (framed_s) begin
        tmr_d = tmr_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        tmr_d = {CNT_W{1'b0}};
      end

      if (send_s) begin
        transmit_d    = 1'b1;
        data_tx_d     = buf_data_q;
        buf_full_d    = 1'b0;
        gap_d         = 2'd2;
        done_d        = resp_in_buf_q && resp_ack_q;
        resp_in_buf_d = 1'b0;
        state_d       = resp_in_buf_q ? S_IDLE : state_q;
      end else begin
        transmit_d = 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (recieved && (data_rx == SYNC)) begin
            state_d    = S_LEN;
            error_d    = 1'b0;
            buf_full_d = 1'b1;
            buf_data_d = data_rx;
            sum_d      = 8'd0;
            mem_addr_d = 8'd0;
          end else begin
            error_d = error_q;
          end
        end
        S_LEN, S_DATA, S_CSUM: begin
          if (recieved && accept_s) begin
            buf_full_d = 1'b1;
            buf_data_d = data_rx;
            case (state_q)
              S_LEN: begin
                cnt_d      = {(data_rx == 8'd0), data_rx};
                sum_d      = 8'd0;
                mem_addr_d = 8'd0;
                state_d    = S_DATA;
              end
              S_DATA: begin
                mem_we_d   = 1'b1;
                mem_data_d = data_rx;
                sum_d      = sum_q + data_rx;
                cnt_d      = cnt_q - 9'd1;
                state_d    = (cnt_q == 9'd1) ? S_CSUM : S_DATA;
              end
              default: begin
                resp_ack_d  = (data_rx == sum_q);
                error_d     = error_q | (data_rx != sum_q);
                resp_pend_d = 1'b1;
                state_d     = S_RESP;
              end
            endcase
          end else if (recieved) begin
            error_d     = 1'b1;
            resp_ack_d  = 1'b0;
            resp_pend_d = 1'b1;
            state_d     = S_RESP;
          end else if (tmr_q >= TMO) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            error_d = error_q;
          end
        end
        S_RESP: begin
          if (resp_pend_q && !buf_full_q) begin
            buf_full_d    = 1'b1;
            buf_data_d    = resp_ack_q ? ACK : NAK;
            resp_pend_d   = 1'b0;
            resp_in_buf_d = 1'b1;
          end else begin
            resp_pend_d = resp_pend_q;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 9'd0;
      sum_q         <= 8'd0;
      mem_addr_q    <= 8'd0;
      buf_full_q    <= 1'b0;
      buf_data_q    <= 8'd0;
      gap_q         <= 2'd0;
      tmr_q         <= {CNT_W{1'b0}};
      error_q       <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_data_q    <= 8'd0;
      transmit_q    <= 1'b0;
      data_tx_q     <= 8'd0;
      done_q        <= 1'b0;
      resp_pend_q   <= 1'b0;
      resp_ack_q    <= 1'b0;
      resp_in_buf_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      mem_addr_q    <= mem_addr_d;
      buf_full_q    <= buf_full_d;
      buf_data_q    <= buf_data_d;
      gap_q         <= gap_d;
      tmr_q         <= tmr_d;
      error_q       <= error_d;
      mem_we_q      <= mem_we_d;
      mem_data_q    <= mem_data_d;
      transmit_q    <= transmit_d;
      data_tx_q     <= data_tx_d;
      done_q        <= done_d;
      resp_pend_q   <= resp_pend_d;
      resp_ack_q    <= resp_ack_d;
      resp_in_buf_q <= resp_in_buf_d;
    end
  end

  assign transmit = transmit_q;
  assign data_tx  = data_tx_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
